alu_sequencer: RTL and testbench

//  Multi-cycle control FSM that sequences one instruction at a time through the 8-bit ALU.
//  Per instruction it: accepts an op from decode; drives ALU operands/opcode; routes the result
//  to the register file, data memory or branch unit; and raises Halt on STOP.

---
 rtl/alu_sequencer_pkg.sv | 46 ++++
 rtl/alu_sequencer_perf.sv | 40 ++++
 rtl/alu_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_sequencer_pkg
// Shared definitions for the ALU sequencer: opcode constants, FSM state type,
// the latched request record and the write-back destination decode.
// Register class opcodes have bit4=0 (operand B from rs).
// Immediate class opcodes have bit4=1 (operand B from imm).
// -----------------------------------------------------------------------------
package alu_sequencer_pkg;

    localparam logic [4:0] kMV   = 5'h00;
    localparam logic [4:0] kADD  = 5'h01;
    localparam logic [4:0] kSUB  = 5'h02;
    localparam logic [4:0] kAND  = 5'h03;
    localparam logic [4:0] kOR   = 5'h04;
    localparam logic [4:0] kXOR  = 5'h05;
    localparam logic [4:0] kSLL  = 5'h06;
    localparam logic [4:0] kLW   = 5'h07;
    localparam logic [4:0] kSW   = 5'h08;
    localparam logic [4:0] kB    = 5'h09;
    localparam logic [4:0] kBLT  = 5'h0A;
    localparam logic [4:0] kBEQ  = 5'h0B;
    localparam logic [4:0] kSTOP = 5'h0C;
    localparam logic [4:0] kLI   = 5'h10;
    localparam logic [4:0] kADDI = 5'h11;

    typedef enum logic [2:0] {IDLE, ACCEPT, EXEC, MEMW, WB, HALT} seq_state_t;

    typedef enum logic [1:0] {DST_NONE, DST_R0, DST_RS} wb_dst_t;

    typedef struct packed {
        logic [4:0] op;
        logic [7:0] imm;
    } seq_req_t;

    // Where the write-back of an op lands; unknown opcodes write nothing.
    function automatic wb_dst_t wb_dst(input logic [4:0] op);
        wb_dst_t d;
        case (op)
            kMV, kLW:                                    d = DST_RS;
            kADD, kSUB, kAND, kOR, kXOR, kSLL, kLI, kADDI: d = DST_R0;
            default:                                     d = DST_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_sequencer_perf.sv
// -----------------------------------------------------------------------------
// alu_seq_perf
// Saturating 16-bit event counters for the sequencer (built only when
// ALU_SEQ_PERF_EN is defined in the top).
// Ports:
//   clk, rst_n     clock, async active-low reset (clears counters)
//   retire         one count per retired instruction
//   stall          one count per ACCEPT cycle without an offered request
//   perf_retired   retire count, saturates at 16'hFFFF
//   perf_stall     stall count, saturates at 16'hFFFF
// -----------------------------------------------------------------------------
module alu_seq_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        retire,
    input  logic        stall,
    output logic [15:0] perf_retired,
    output logic [15:0] perf_stall
);

    logic [1:0][15:0] cnt;
    logic [1:0]       inc;

    assign inc = {stall, retire};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (inc[i] && cnt[i] != 16'hFFFF)
                    cnt[i] <= cnt[i] + 16'd1;
            end
        end
    end

    assign perf_retired = cnt[0];
    assign perf_stall   = cnt[1];

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle control FSM moving one instruction at a time through the 8-bit
// ALU: ACCEPT -> EXEC -> (MEMW for LW) -> WB, with HALT entered on STOP.
// Optional feature macro: ALU_SEQ_PERF_EN adds perf_retired / perf_stall.
// Ports:
//   Clk, Reset_n            clock, async active-low reset
//   Start / Halt            run control (level in) / halted status
//   req_*                   valid/ready instruction offer from decode
//   rf_raddr, rf_rdata_a/b  register reads (port A is always r0)
//   rf_we/waddr/wdata       register write, pulsed in WB
//   alu_op/a/b, alu_out/eq/lt  external ALU, driven during EXEC only
//   mem_re/we/addr/wdata/rdata data memory
//   flag_eq, flag_lt        compare flags, updated only by BEQ / BLT
//   br_taken, br_target     branch pulse and latched target
//   retire                  one pulse per completed instruction
// -----------------------------------------------------------------------------
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int RAW     = 4,
    parameter int MEM_LAT = 1
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           Start,
    output logic           Halt,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [4:0]     req_op,
    input  logic [RAW-1:0] req_rs,
    input  logic [7:0]     req_imm,
    output logic [RAW-1:0] rf_raddr,
    input  logic [7:0]     rf_rdata_a,
    input  logic [7:0]     rf_rdata_b,
    output logic           rf_we,
    output logic [RAW-1:0] rf_waddr,
    output logic [7:0]     rf_wdata,
    output logic [4:0]     alu_op,
    output logic [7:0]     alu_a,
    output logic [7:0]     alu_b,
    input  logic [7:0]     alu_out,
    input  logic           alu_eq,
    input  logic           alu_lt,
    output logic           mem_re,
    output logic           mem_we,
    output logic [7:0]     mem_addr,
    output logic [7:0]     mem_wdata,
    input  logic [7:0]     mem_rdata,
    output logic           flag_eq,
    output logic           flag_lt,
    output logic           br_taken,
    output logic [7:0]     br_target,
    output logic           retire
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0]    perf_retired,
    output logic [15:0]    perf_stall
`endif
);

    localparam logic [2:0] LAST = 3'(MEM_LAT - 1);

    seq_state_t     state, nstate;
    seq_req_t       req_q;
    logic [RAW-1:0] rs_q;
    logic [7:0]     res_q;
    logic [7:0]     mdata_q;
    logic [2:0]     cnt_q;
    logic           start_q;
    wb_dst_t        dst;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            req_q   <= '0;
            rs_q    <= '0;
            res_q   <= '0;
            mdata_q <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            flag_eq <= 1'b0;
            flag_lt <= 1'b0;
        end else begin
            state   <= nstate;
            start_q <= Start;
            if (state == ACCEPT && req_valid) begin
                req_q <= '{op: req_op, imm: req_imm};
                rs_q  <= req_rs;
            end
            // Flags are only sampled from the ALU on the compare ops, so they
            // are already valid for the branch decision in WB.
            if (state == EXEC) begin
                res_q <= alu_out;
                if (req_q.op == kBEQ) flag_eq <= alu_eq;
                if (req_q.op == kBLT) flag_lt <= alu_lt;
            end
            cnt_q <= (state == MEMW) ? cnt_q + 3'd1 : 3'd0;
            if (state == MEMW && cnt_q == LAST)
                mdata_q <= mem_rdata;
        end
    end

    assign dst       = wb_dst(req_q.op);
    assign rf_raddr  = rs_q;
    assign br_target = req_q.imm;

    always_comb begin
        nstate    = state;
        Halt      = 1'b0;
        req_ready = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        alu_op    = '0;
        alu_a     = '0;
        alu_b     = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        br_taken  = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                if (Start) nstate = ACCEPT;
            end
            ACCEPT: begin
                req_ready = 1'b1;
                if (req_valid) nstate = EXEC;
            end
            EXEC: begin
                alu_op = req_q.op;
                alu_a  = rf_rdata_a;
                alu_b  = req_q.op[4] ? req_q.imm : rf_rdata_b;
                if (req_q.op == kSLL) alu_b = {7'b0, req_q.imm[0]};
                nstate = (req_q.op == kLW) ? MEMW : WB;
            end
            MEMW: begin
                mem_re   = 1'b1;
                mem_addr = res_q;
                if (cnt_q == LAST) nstate = WB;
            end
            WB: begin
                retire = 1'b1;
                nstate = ACCEPT;
                case (dst)
                    DST_R0: begin
                        rf_we    = 1'b1;
                        rf_wdata = res_q;
                    end
                    DST_RS: begin
                        rf_we    = 1'b1;
                        rf_waddr = rs_q;
                        rf_wdata = (req_q.op == kLW) ? mdata_q : res_q;
                    end
                    default: ;
                endcase
                case (req_q.op)
                    kSW: begin
                        mem_we    = 1'b1;
                        mem_addr  = rf_rdata_a;
                        mem_wdata = rf_rdata_b;
                    end
                    kB:      br_taken = 1'b1;
                    kBEQ:    br_taken = flag_eq;
                    kBLT:    br_taken = flag_lt;
                    kSTOP:   nstate   = HALT;
                    default: ;
                endcase
            end
            HALT: begin
                Halt = 1'b1;
                // Leave only on a fresh rising edge so a held Start cannot
                // immediately restart past a STOP.
                if (Start && !start_q) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

`ifdef ALU_SEQ_PERF_EN
    alu_seq_perf u_perf (
        .clk          (Clk),
        .rst_n        (Reset_n),
        .retire       (retire),
        .stall        (state == ACCEPT && !req_valid),
        .perf_retired (perf_retired),
        .perf_stall   (perf_stall)
    );
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Bench for alu_sequencer with a behavioural ALU, register file and memory.
// Each issued instruction's expected write-back is predicted from the
// architectural state and queued; a monitor compares on every retire.
// Latency counts the transfer cycle as cycle 1 through the retire cycle.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    localparam int RAW     = 4;
    localparam int MEM_LAT = 2;

    typedef logic [79:0] v_t;

    typedef struct {
        bit         we;
        logic [3:0] waddr;
        logic [7:0] wdata;
        bit         mwe;
        logic [7:0] maddr;
        logic [7:0] mwdata;
        bit         br;
        logic [7:0] btgt;
        logic [7:0] ldaddr;
        bit         feq;
        bit         flt;
        int         lat;
    } exp_t;

    localparam logic [4:0] OPS [17] = '{kMV, kADD, kSUB, kAND, kOR, kXOR, kSLL, kLW, kSW,
                                        kB, kBLT, kBEQ, kLI, kADDI, 5'h0D, 5'h15, 5'h1F};
    localparam logic [4:0] ALUOPS [8] = '{kMV, kADD, kSUB, kAND, kOR, kXOR, kSLL, kLI};

    logic           Clk, Reset_n, Start, Halt, req_valid, req_ready;
    logic [4:0]     req_op;
    logic [RAW-1:0] req_rs, rf_raddr, rf_waddr;
    logic [7:0]     req_imm, rf_rdata_a, rf_rdata_b, rf_wdata;
    logic           rf_we;
    logic [4:0]     alu_op;
    logic [7:0]     alu_a, alu_b, alu_out;
    logic           alu_eq, alu_lt;
    logic           mem_re, mem_we;
    logic [7:0]     mem_addr, mem_wdata, mem_rdata;
    logic           flag_eq, flag_lt, br_taken, retire;
    logic [7:0]     br_target;
`ifdef ALU_SEQ_PERF_EN
    logic [15:0]    perf_retired, perf_stall;
`endif

    // environment state
    logic [7:0] rf  [16];
    logic [7:0] mem [256];
    logic [1:0] pl_kind;
    logic [7:0] pl_idx, pl_val;

    // reference model state
    logic [7:0] mrf  [16];
    logic [7:0] mmem [256];
    bit         mflag_eq, mflag_lt;
    exp_t       sb [$];

    int nchk = 0, nerr = 0, cyc = 0, tcyc = 0;

    logic [69:0] outs;
    assign outs = {Halt, req_ready, rf_raddr, rf_we, rf_waddr, rf_wdata, alu_op, alu_a, alu_b,
                   mem_re, mem_we, mem_addr, mem_wdata, flag_eq, flag_lt, br_taken, br_target,
                   retire};

    alu_sequencer #(.RAW(RAW), .MEM_LAT(MEM_LAT)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt(Halt),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rs(req_rs),
        .req_imm(req_imm), .rf_raddr(rf_raddr), .rf_rdata_a(rf_rdata_a),
        .rf_rdata_b(rf_rdata_b), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_eq(alu_eq),
        .alu_lt(alu_lt), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .flag_eq(flag_eq), .flag_lt(flag_lt),
        .br_taken(br_taken), .br_target(br_target), .retire(retire)
`ifdef ALU_SEQ_PERF_EN
        , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got still running, required finished");
        $fatal(1, "watchdog");
    end

    // behavioural ALU
    always_comb begin
        case (alu_op)
            kMV, kLW: alu_out = alu_a;
            kADD, kADDI: alu_out = alu_a + alu_b;
            kSUB:   alu_out = alu_a - alu_b;
            kAND:   alu_out = alu_a & alu_b;
            kOR:    alu_out = alu_a | alu_b;
            kXOR:   alu_out = alu_a ^ alu_b;
            kSLL:   alu_out = alu_a << alu_b[2:0];
            kLI:    alu_out = alu_b;
            default: alu_out = 8'h00;
        endcase
        alu_eq = (alu_a == alu_b);
        alu_lt = (alu_a < alu_b);
    end

    assign rf_rdata_a = rf[0];
    assign rf_rdata_b = rf[rf_raddr];
    assign mem_rdata  = mem_re ? mem[mem_addr] : 8'h00;

    always @(posedge Clk) begin
        cyc = cyc + 1;
        if (rf_we) rf[rf_waddr] <= rf_wdata;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (pl_kind == 2'd1) rf[pl_idx[3:0]] <= pl_val;
        if (pl_kind == 2'd2) mem[pl_idx] <= pl_val;
    end

    function automatic void chk(input string nm, input v_t act, input v_t exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endfunction

    // Architectural prediction of one instruction; state updated immediately
    // since only one instruction is ever in flight.
    task automatic predict(input logic [4:0] op, input logic [3:0] rs, input logic [7:0] imm);
        exp_t e;
        logic [7:0] a, b;
        a = mrf[0];
        b = mrf[rs];
        e = '{we: 0, waddr: 0, wdata: 0, mwe: 0, maddr: 0, mwdata: 0, br: 0,
              btgt: imm, ldaddr: 0, feq: 0, flt: 0, lat: 3};
        case (op)
            kMV:   begin e.we = 1; e.waddr = rs; e.wdata = a; end
            kADD:  begin e.we = 1; e.wdata = a + b; end
            kSUB:  begin e.we = 1; e.wdata = a - b; end
            kAND:  begin e.we = 1; e.wdata = a & b; end
            kOR:   begin e.we = 1; e.wdata = a | b; end
            kXOR:  begin e.we = 1; e.wdata = a ^ b; end
            kSLL:  begin e.we = 1; e.wdata = imm[0] ? {a[6:0], 1'b0} : a; end
            kLI:   begin e.we = 1; e.wdata = imm; end
            kADDI: begin e.we = 1; e.wdata = a + imm; end
            kLW:   begin e.we = 1; e.waddr = rs; e.wdata = mmem[a]; e.ldaddr = a;
                         e.lat = 3 + MEM_LAT; end
            kSW:   begin e.mwe = 1; e.maddr = a; e.mwdata = b; end
            kB:    e.br = 1;
            kBEQ:  begin mflag_eq = (a == b); e.br = mflag_eq; end
            kBLT:  begin mflag_lt = (a < b);  e.br = mflag_lt; end
            default: ;
        endcase
        e.feq = mflag_eq;
        e.flt = mflag_lt;
        if (e.we)  mrf[e.waddr] = e.wdata;
        if (e.mwe) mmem[e.maddr] = e.mwdata;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic preload_reg(input int i, input logic [7:0] v);
        pl_kind = 2'd1; pl_idx = 8'(i); pl_val = v;
        mrf[i] = v;
        tick();
        pl_kind = 2'd0;
    endtask

    task automatic preload_mem(input int i, input logic [7:0] v);
        pl_kind = 2'd2; pl_idx = 8'(i); pl_val = v;
        mmem[i] = v;
        tick();
        pl_kind = 2'd0;
    endtask

    task automatic issue(input logic [4:0] op, input logic [3:0] rs, input logic [7:0] imm);
        bit done = 0;
        int n = 0;
        predict(op, rs, imm);
        req_op = op; req_rs = rs; req_imm = imm; req_valid = 1'b1;
        while (!done && n < 50) begin
            @(negedge Clk);
            done = req_ready;
            tick();
            n++;
        end
        chk("issue_accepted", v_t'(done), v_t'(1));
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("drain", v_t'(sb.size()), v_t'(0));
        tick();
    endtask

    task automatic idle_accept(input int k);
        int c = 0, g = 0;
        while (c < k && g < 100) begin
            @(negedge Clk);
            if (req_ready) c++;
            tick();
            g++;
        end
    endtask

    // scoreboard monitor
    always @(negedge Clk) begin : mon
        exp_t e;
        if (Reset_n) begin
            chk("pulse_outside_wb", v_t'({rf_we, mem_we, br_taken} & {3{~retire}}), v_t'(0));
            if (req_valid && req_ready) tcyc = cyc;
            if (mem_re) begin
                if (sb.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL memw: mem_re with nothing in flight, actual 1 required 0");
                end else begin
                    chk("memw_addr", v_t'(mem_addr), v_t'(sb[0].ldaddr));
                end
            end
            if (retire) begin
                if (sb.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL retire: unexpected retire, actual 1 required 0");
                end else begin
                    e = sb.pop_front();
                    chk("rf_we", v_t'(rf_we), v_t'(e.we));
                    if (e.we) begin
                        chk("rf_waddr", v_t'(rf_waddr), v_t'(e.waddr));
                        chk("rf_wdata", v_t'(rf_wdata), v_t'(e.wdata));
                    end
                    chk("mem_we", v_t'(mem_we), v_t'(e.mwe));
                    if (e.mwe) begin
                        chk("sw_addr", v_t'(mem_addr), v_t'(e.maddr));
                        chk("sw_wdata", v_t'(mem_wdata), v_t'(e.mwdata));
                    end
                    chk("br_taken", v_t'(br_taken), v_t'(e.br));
                    if (e.br) chk("br_target", v_t'(br_target), v_t'(e.btgt));
                    chk("flag_eq", v_t'(flag_eq), v_t'(e.feq));
                    chk("flag_lt", v_t'(flag_lt), v_t'(e.flt));
                    chk("latency", v_t'(cyc - tcyc + 1), v_t'(e.lat));
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] sv;
        int n;
        bit anywe;
        Reset_n = 1'b0; Start = 1'b0; req_valid = 1'b0;
        req_op = '0; req_rs = '0; req_imm = '0;
        pl_kind = 2'd0; pl_idx = '0; pl_val = '0;
        mflag_eq = 0; mflag_lt = 0;
        tick(); tick();
        chk("reset_outputs", v_t'(outs), v_t'(0));
`ifdef ALU_SEQ_PERF_EN
        chk("reset_perf", v_t'({perf_retired, perf_stall}), v_t'(0));
`endif
        for (int i = 0; i < 16; i++) preload_reg(i, 8'($urandom));
        for (int i = 0; i < 256; i++) preload_mem(i, 8'($urandom));
        Reset_n = 1'b1;
        tick(); tick();
        chk("idle_without_start", v_t'({Halt, req_ready}), v_t'(0));
        Start = 1'b1;
        tick();

        // ADD r0=5 + r3=7
        preload_reg(0, 8'd5); preload_reg(3, 8'd7);
        issue(kADD, 4'd3, 8'h00);
        drain();
        // BEQ taken with equal operands
        preload_reg(0, 8'd3); preload_reg(2, 8'd3);
        issue(kBEQ, 4'd2, 8'h40);
        drain();
        chk("beq_flag_eq_held", v_t'(flag_eq), v_t'(1));
        // LW through the memory wait states
        preload_reg(0, 8'h10); preload_mem(8'h10, 8'hA5);
        issue(kLW, 4'd4, 8'h00);
        drain();
        chk("lw_r4", v_t'(rf[4]), v_t'(8'hA5));

        for (int k = 0; k < 40; k++) begin
            n = int'($urandom_range(0, 16));
            issue(OPS[n], 4'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();

        // STOP and restart on a fresh Start edge
        issue(kSTOP, 4'd0, 8'h00);
        n = 0;
        while (!Halt && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("halt_entered", v_t'(Halt), v_t'(1));
        chk("halt_not_ready", v_t'(req_ready), v_t'(0));
        repeat (5) tick();
        chk("halt_held_start", v_t'(Halt), v_t'(1));
        Start = 1'b0;
        tick(); tick();
        chk("halt_start_low", v_t'(Halt), v_t'(1));
        Start = 1'b1;
        tick();
        chk("halt_exit_idle", v_t'({Halt, req_ready}), v_t'(0));
        tick();
        chk("accept_after_halt", v_t'(req_ready), v_t'(1));
        drain();

        // reset in the middle of a load
        sv = mrf[4];
        issue(kLW, 4'd4, 8'h00);
        n = 0;
        while (!mem_re && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("reach_memw", v_t'(mem_re), v_t'(1));
        #2 Reset_n = 1'b0;
        #1 chk("abort_outputs", v_t'(outs), v_t'(0));
        sb.delete();
        mrf[4] = sv;
        mflag_eq = 0; mflag_lt = 0;
        Start = 1'b0;
        tick(); tick();
        Reset_n = 1'b1;
        anywe = 0;
        repeat (6) begin
            @(negedge Clk);
            anywe |= rf_we;
        end
        chk("no_we_after_abort", v_t'(anywe), v_t'(0));
        chk("r4_unchanged", v_t'(rf[4]), v_t'(sv));
        tick();

        // 10 ALU ops with exactly 4 idle ACCEPT cycles
        Start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            n = int'($urandom_range(0, 7));
            issue(ALUOPS[n], 4'($urandom), 8'($urandom));
            if (k == 4) idle_accept(4);
        end
`ifdef ALU_SEQ_PERF_EN
        repeat (3) @(negedge Clk);
        chk("perf_retired", v_t'(perf_retired), v_t'(10));
        chk("perf_stall", v_t'(perf_stall), v_t'(4));
`endif
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
